// File: rtl/d20_roll_gen.sv
// d20 roll source: a Galois LFSR is rejection-sampled into 1..MAX_FACE, with a forced fold after MAX_TRIES rejects.
// Latency is 1 cycle after req plus 1 per rejected draw; the roll is held on valid/ready until roll_ready.
module d20_roll_gen #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter int                    MAX_FACE   = 20,
  parameter int                    MAX_TRIES  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  req,
  output logic                  busy,
  output logic                  roll_valid,
  input  logic                  roll_ready,
  output logic [4:0]            roll,
  output logic                  forced,
  output logic [7:0]            reject_count,
  output logic [15:0]           roll_count
);

  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [4:0]       FACE_MAX  = 5'(MAX_FACE);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_HOLD
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LFSR_WIDTH-1:0]   r_lfsr;
  logic [TRY_W-1:0]        r_tries;
  logic [4:0]              r_roll;
  logic                    r_forced;
  logic                    r_valid;
  logic [7:0]              r_reject_count;
  logic [15:0]             r_roll_count;

  logic [4:0]              w_cand;
  logic                    w_legal;
  logic [4:0]              w_fold;
  logic [LFSR_WIDTH-1:0]   w_lfsr_step;
  logic [TRY_W-1:0]        w_tries_inc;
  logic                    w_tries_hit;
  logic                    w_start;
  logic                    w_step;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_force;
  logic                    w_handshake;

  assign w_cand      = r_lfsr[4:0];
  assign w_legal     = (w_cand != 5'd0) && (w_cand <= FACE_MAX);
  assign w_fold      = (w_cand % FACE_MAX) + 5'd1;
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_tries_inc = r_tries + TRY_W'(1);
  assign w_tries_hit = (w_tries_inc >= TRY_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // seed_load overrides every other event, including an accepting draw
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_force     = 1'b0;
    w_handshake = 1'b0;
    if (seed_load) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            w_start     = 1'b1;
            w_state_nxt = S_DRAW;
          end
        end
        S_DRAW: begin
          w_step = 1'b1;
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_reject = 1'b1;
            if (w_tries_hit) begin
              w_force     = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (roll_ready) begin
            w_handshake = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr         <= SEED;
      r_tries        <= '0;
      r_roll         <= 5'd0;
      r_forced       <= 1'b0;
      r_valid        <= 1'b0;
      r_reject_count <= 8'd0;
      r_roll_count   <= 16'd0;
    end else if (seed_load) begin
      r_lfsr  <= (seed_in == '0) ? SEED : seed_in;
      r_tries <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_step) r_lfsr <= w_lfsr_step;
      if (w_start) r_tries <= '0;
      if (w_accept) begin
        r_roll   <= w_cand;
        r_forced <= 1'b0;
        r_valid  <= 1'b1;
      end
      if (w_reject) begin
        r_tries <= w_tries_inc;
        if (r_reject_count != 8'hFF) r_reject_count <= r_reject_count + 8'd1;
      end
      if (w_force) begin
        r_roll   <= w_fold;
        r_forced <= 1'b1;
        r_valid  <= 1'b1;
      end
      if (w_handshake) begin
        r_valid      <= 1'b0;
        r_roll_count <= r_roll_count + 16'd1;
      end
    end
  end

  assign busy         = (r_state == S_DRAW);
  assign roll_valid   = r_valid;
  assign roll         = r_roll;
  assign forced       = r_forced;
  assign reject_count = r_reject_count;
  assign roll_count   = r_roll_count;

endmodule

// File: tb/tb_d20_roll_gen.sv
// Directed bench for d20_roll_gen: default instance plus a MAX_TRIES=1 instance sharing the same inputs.
module tb_d20_roll_gen;

  logic        clk;
  logic        reset_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic        roll_ready;

  logic        busy, roll_valid, forced;
  logic [4:0]  roll;
  logic [7:0]  reject_count;
  logic [15:0] roll_count;

  logic        d1_busy, d1_roll_valid, d1_forced;
  logic [4:0]  d1_roll;
  logic [7:0]  d1_reject_count;
  logic [15:0] d1_roll_count;

  int checks = 0;
  int errors = 0;

  d20_roll_gen u_dut (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(busy), .roll_valid(roll_valid), .roll_ready(roll_ready),
    .roll(roll), .forced(forced), .reject_count(reject_count), .roll_count(roll_count)
  );

  d20_roll_gen #(.MAX_TRIES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(d1_busy), .roll_valid(d1_roll_valid), .roll_ready(roll_ready),
    .roll(d1_roll), .forced(d1_forced), .reject_count(d1_reject_count),
    .roll_count(d1_roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    step();
    seed_load = 1'b0;
  endtask

  task automatic request();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic handshake();
    roll_ready = 1'b1;
    step();
    roll_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    seed_load  = 1'b0;
    seed_in    = 16'h0000;
    req        = 1'b0;
    roll_ready = 1'b0;
    #2;
    chk("rst_valid", roll_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_roll", roll, 0);
    chk("rst_forced", forced, 0);
    chk("rst_rej", reject_count, 0);
    chk("rst_rcnt", roll_count, 0);
    step();
    reset_n = 1'b1;

    // forced fallback with MAX_TRIES=1: candidate 0 folds to 1, 31 folds to 12
    load_seed(16'h0020);
    request();
    step();
    chk("f0_valid", d1_roll_valid, 1);
    chk("f0_roll", d1_roll, 1);
    chk("f0_forced", d1_forced, 1);
    chk("f0_rej", d1_reject_count, 1);
    step();
    handshake();
    chk("f0_hs_valid", d1_roll_valid, 0);
    chk("f0_hs_rcnt", d1_roll_count, 1);
    load_seed(16'h001F);
    request();
    step();
    chk("f31_roll", d1_roll, 12);
    chk("f31_forced", d1_forced, 1);
    chk("f31_rej", d1_reject_count, 2);
    step();
    handshake();
    pulse_reset();

    // first candidate legal, held until ready
    load_seed(16'h0005);
    request();
    chk("t1_busy", busy, 1);
    chk("t1_early_valid", roll_valid, 0);
    step();
    chk("t1_valid", roll_valid, 1);
    chk("t1_roll", roll, 5);
    chk("t1_forced", forced, 0);
    chk("t1_rej", reject_count, 0);
    chk("t1_busy_hold", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_hold_roll", roll, 5);
      chk("t1_hold_valid", roll_valid, 1);
    end
    handshake();
    chk("t1_hs_valid", roll_valid, 0);
    chk("t1_hs_rcnt", roll_count, 1);

    // one rejection: 0x0015 -> 0xB40A
    load_seed(16'h0015);
    request();
    step();
    chk("t2_rej_valid", roll_valid, 0);
    chk("t2_rej", reject_count, 1);
    chk("t2_busy", busy, 1);
    step();
    chk("t2_valid", roll_valid, 1);
    chk("t2_roll", roll, 10);
    handshake();
    chk("t2_rcnt", roll_count, 2);

    // zero seed substitutes SEED, whose low bits give 1
    load_seed(16'h0000);
    request();
    step();
    chk("t3_roll", roll, 1);
    chk("t3_valid", roll_valid, 1);
    handshake();
    chk("t3_rcnt", roll_count, 3);

    // seed_load aborting a draw, with req asserted alongside
    load_seed(16'h0015);
    request();
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    req       = 1'b1;
    step();
    seed_load = 1'b0;
    req       = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_valid", roll_valid, 0);
    chk("t5_abort_rej", reject_count, 1);
    chk("t5_abort_rcnt", roll_count, 3);
    step();
    chk("t5_idle_valid", roll_valid, 0);
    chk("t5_idle_busy", busy, 0);

    // req held through DRAW, HOLD and the handshake yields only one roll
    load_seed(16'h0015);
    request();
    req = 1'b1;
    step();
    step();
    chk("t5_busyreq_roll", roll, 10);
    handshake();
    req = 1'b0;
    step();
    chk("t5_busyreq_busy", busy, 0);
    chk("t5_busyreq_valid", roll_valid, 0);
    chk("t5_busyreq_rcnt", roll_count, 4);

    // seed_load in HOLD drops valid but keeps roll
    load_seed(16'h0005);
    request();
    step();
    chk("t5_hold_valid", roll_valid, 1);
    load_seed(16'h0005);
    chk("t5_hold_abort_valid", roll_valid, 0);
    chk("t5_hold_abort_roll", roll, 5);
    chk("t5_hold_abort_rcnt", roll_count, 4);

    // asynchronous reset in HOLD
    load_seed(16'h0005);
    request();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_arst_valid", roll_valid, 0);
    chk("t6_arst_rcnt", roll_count, 0);
    chk("t6_arst_rej", reject_count, 0);
    chk("t6_arst_roll", roll, 0);
    reset_n = 1'b1;

    // reject_count saturation: each roll from 0x0020 rejects once then yields 16
    for (int i = 0; i < 300; i++) begin
      load_seed(16'h0020);
      request();
      step();
      step();
      if (i == 0) chk("t6_sat_roll", roll, 16);
      handshake();
      if (i == 254) chk("t6_sat_255", reject_count, 255);
    end
    chk("t6_sat_final", reject_count, 255);
    chk("t6_sat_rcnt", roll_count, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
